// File: rtl/iq_alloc.sv
// Issue-queue entry allocator: hands out the two lowest free entries per cycle and reclaims them.
// Define IQ_ALLOC_SELECTIVE_FLUSH_EN for age-based flush on prmiss; the default flushes everything.
module iq_alloc #(
    parameter int ENT_NUM = 16,
    parameter int ENT_SEL = 4,
    parameter int ROB_SEL = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_1,
    input  logic               req_2,
    input  logic               stall_DP,
    input  logic [ROB_SEL-1:0] rob_num_1,
    input  logic [ROB_SEL-1:0] rob_num_2,
    input  logic               rob_sorting_bit_1,
    input  logic               rob_sorting_bit_2,
    input  logic               free_en_1,
    input  logic               free_en_2,
    input  logic [ENT_SEL-1:0] free_idx_1,
    input  logic [ENT_SEL-1:0] free_idx_2,
    input  logic               prmiss,
    input  logic [ROB_SEL-1:0] prmiss_rob_num,
    input  logic               prmiss_rob_sorting_bit,
    output logic [ENT_SEL-1:0] iq_entry_num_1,
    output logic [ENT_SEL-1:0] iq_entry_num_2,
    output logic               allocatable,
    output logic [ENT_SEL:0]   free_cnt
);

    logic [ENT_NUM-1:0] busy;
    logic [ENT_NUM-1:0] busy_next;
    logic [ENT_SEL:0]   cnt_next;
    logic               alloc_1;
    logic               alloc_2;
    logic               rel_1;
    logic               rel_2;
    logic               found_1;
    logic               found_2;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        iq_entry_num_1 = '0;
        iq_entry_num_2 = '0;
        found_1        = 1'b0;
        found_2        = 1'b0;
        for (int i = 0; i < ENT_NUM; i++) begin
            if (!busy[i]) begin
                if (!found_1) begin
                    iq_entry_num_1 = ENT_SEL'(i);
                    found_1        = 1'b1;
                end else if (!found_2) begin
                    iq_entry_num_2 = ENT_SEL'(i);
                    found_2        = 1'b1;
                end
            end
        end
    end

    assign allocatable = (free_cnt >= (ENT_SEL+1)'(2));
    assign alloc_1     = req_1 & ~stall_DP & ~prmiss & allocatable;
    assign alloc_2     = req_2 & ~stall_DP & ~prmiss & allocatable;
    // A release only counts if the entry is busy and was not already named by the other port.
    assign rel_1       = free_en_1 & busy[free_idx_1];
    assign rel_2       = free_en_2 & busy[free_idx_2] & ~(free_en_1 & (free_idx_1 == free_idx_2));

`ifdef IQ_ALLOC_SELECTIVE_FLUSH_EN
    logic [ROB_SEL-1:0] rob [ENT_NUM];
    logic [ENT_NUM-1:0] sb;
    logic [ENT_NUM-1:0] younger;

    always_comb begin
        for (int i = 0; i < ENT_NUM; i++) begin
            younger[i] = (sb[i] == prmiss_rob_sorting_bit) ? (rob[i] > prmiss_rob_num)
                                                           : (rob[i] < prmiss_rob_num);
        end
    end

    // NOTE: tag storage is deliberately not reset; busy alone decides whether a tag is meaningful.
    always_ff @(posedge clk) begin
        if (alloc_1) begin
            rob[iq_entry_num_1] <= rob_num_1;
            sb[iq_entry_num_1]  <= rob_sorting_bit_1;
        end
        if (alloc_2) begin
            rob[iq_entry_num_2] <= rob_num_2;
            sb[iq_entry_num_2]  <= rob_sorting_bit_2;
        end
    end
`else
    logic unused_tags;
    assign unused_tags = ^{rob_num_1, rob_num_2, rob_sorting_bit_1, rob_sorting_bit_2,
                           prmiss_rob_num, prmiss_rob_sorting_bit};
`endif

    always_comb begin
        busy_next = busy;
        if (rel_1) busy_next[free_idx_1] = 1'b0;
        if (rel_2) busy_next[free_idx_2] = 1'b0;
        cnt_next = free_cnt + (ENT_SEL+1)'(rel_1) + (ENT_SEL+1)'(rel_2);
        if (prmiss) begin
`ifdef IQ_ALLOC_SELECTIVE_FLUSH_EN
            for (int i = 0; i < ENT_NUM; i++) begin
                if (busy_next[i] && younger[i]) begin
                    busy_next[i] = 1'b0;
                    cnt_next     = cnt_next + (ENT_SEL+1)'(1);
                end
            end
`else
            busy_next = '0;
            cnt_next  = (ENT_SEL+1)'(ENT_NUM);
`endif
        end else begin
            if (alloc_1) busy_next[iq_entry_num_1] = 1'b1;
            if (alloc_2) busy_next[iq_entry_num_2] = 1'b1;
            cnt_next = cnt_next - (ENT_SEL+1)'(alloc_1) - (ENT_SEL+1)'(alloc_2);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= '0;
            free_cnt <= (ENT_SEL+1)'(ENT_NUM);
        end else begin
            busy     <= busy_next;
            free_cnt <= cnt_next;
        end
    end

endmodule

// File: tb/tb_iq_alloc.sv
// Self-checking bench for iq_alloc: free-list model compared every cycle, plus hand-computed pins.
// Covers both IQ_ALLOC_SELECTIVE_FLUSH_EN builds.
module tb_iq_alloc;

    localparam int ENT_NUM = 16;
    localparam int ENT_SEL = 4;
    localparam int ROB_SEL = 6;

    typedef int int_q_t[$];

    logic               clk = 1'b0;
    logic               reset;
    logic               req_1, req_2, stall_DP;
    logic [ROB_SEL-1:0] rob_num_1, rob_num_2;
    logic               rob_sorting_bit_1, rob_sorting_bit_2;
    logic               free_en_1, free_en_2;
    logic [ENT_SEL-1:0] free_idx_1, free_idx_2;
    logic               prmiss;
    logic [ROB_SEL-1:0] prmiss_rob_num;
    logic               prmiss_rob_sorting_bit;
    logic [ENT_SEL-1:0] iq_entry_num_1, iq_entry_num_2;
    logic               allocatable;
    logic [ENT_SEL:0]   free_cnt;

    int errors = 0;
    int checks = 0;

    bit model_valid = 1'b0;
    bit busy_m [ENT_NUM];
    int rob_m  [ENT_NUM];
    bit sb_m   [ENT_NUM];

    iq_alloc #(.ENT_NUM(ENT_NUM), .ENT_SEL(ENT_SEL), .ROB_SEL(ROB_SEL)) dut (
        .clk(clk), .reset(reset),
        .req_1(req_1), .req_2(req_2), .stall_DP(stall_DP),
        .rob_num_1(rob_num_1), .rob_num_2(rob_num_2),
        .rob_sorting_bit_1(rob_sorting_bit_1), .rob_sorting_bit_2(rob_sorting_bit_2),
        .free_en_1(free_en_1), .free_en_2(free_en_2),
        .free_idx_1(free_idx_1), .free_idx_2(free_idx_2),
        .prmiss(prmiss), .prmiss_rob_num(prmiss_rob_num),
        .prmiss_rob_sorting_bit(prmiss_rob_sorting_bit),
        .iq_entry_num_1(iq_entry_num_1), .iq_entry_num_2(iq_entry_num_2),
        .allocatable(allocatable), .free_cnt(free_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Free entries in ascending order, straight from the model occupancy.
    function automatic int_q_t free_list();
        int_q_t q;
        for (int i = 0; i < ENT_NUM; i++) if (!busy_m[i]) q.push_back(i);
        return q;
    endfunction

    // Advance the model by one clock edge using the inputs held during that cycle.
    task automatic model_update();
        int_q_t q;
        if (reset) begin
            foreach (busy_m[i]) busy_m[i] = 1'b0;
            model_valid = 1'b1;
            return;
        end
        if (!model_valid) return;
        q = free_list();
        if (free_en_1) busy_m[free_idx_1] = 1'b0;
        if (free_en_2) busy_m[free_idx_2] = 1'b0;
        if (prmiss) begin
            foreach (busy_m[i]) begin
`ifdef IQ_ALLOC_SELECTIVE_FLUSH_EN
                if ((sb_m[i] == prmiss_rob_sorting_bit) ? (rob_m[i] > int'(prmiss_rob_num))
                                                        : (rob_m[i] < int'(prmiss_rob_num)))
                    busy_m[i] = 1'b0;
`else
                busy_m[i] = 1'b0;
`endif
            end
        end else if (!stall_DP && q.size() >= 2) begin
            if (req_1) begin
                busy_m[q[0]] = 1'b1; rob_m[q[0]] = int'(rob_num_1); sb_m[q[0]] = rob_sorting_bit_1;
            end
            if (req_2) begin
                busy_m[q[1]] = 1'b1; rob_m[q[1]] = int'(rob_num_2); sb_m[q[1]] = rob_sorting_bit_2;
            end
        end
    endtask

    always @(negedge clk) begin
        int_q_t q;
        if (model_valid) begin
            q = free_list();
            check("free_cnt_vs_model", int'(free_cnt), q.size());
            check("allocatable_vs_model", int'(allocatable), int'(q.size() >= 2));
            if (q.size() >= 1) check("entry_1_vs_model", int'(iq_entry_num_1), q[0]);
            if (q.size() >= 2) check("entry_2_vs_model", int'(iq_entry_num_2), q[1]);
        end
    end

    task automatic idle();
        req_1 = 0; req_2 = 0; stall_DP = 0;
        rob_num_1 = '0; rob_num_2 = '0; rob_sorting_bit_1 = 0; rob_sorting_bit_2 = 0;
        free_en_1 = 0; free_en_2 = 0; free_idx_1 = '0; free_idx_2 = '0;
        prmiss = 0; prmiss_rob_num = '0; prmiss_rob_sorting_bit = 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        idle();
    endtask

    task automatic pin(input string tag, input int e1, input int e2, input int al, input int cnt);
        if (e1 >= 0) check({tag, "_entry_1"}, int'(iq_entry_num_1), e1);
        if (e2 >= 0) check({tag, "_entry_2"}, int'(iq_entry_num_2), e2);
        check({tag, "_allocatable"}, int'(allocatable), al);
        check({tag, "_free_cnt"}, int'(free_cnt), cnt);
    endtask

    task automatic do_reset();
        reset = 1; idle(); step(); reset = 0;
    endtask

    task automatic alloc2(input int r1, input int s1, input int r2, input int s2);
        req_1 = 1; req_2 = 1;
        rob_num_1 = ROB_SEL'(r1); rob_sorting_bit_1 = s1[0];
        rob_num_2 = ROB_SEL'(r2); rob_sorting_bit_2 = s2[0];
        step();
    endtask

    initial begin
        reset = 1; idle();
        step(); step();
        reset = 0;
        pin("reset", 0, 1, 1, 16);

        for (int k = 0; k < 3; k++) begin
            check("burst_entry_1", int'(iq_entry_num_1), 2 * k);
            check("burst_entry_2", int'(iq_entry_num_2), 2 * k + 1);
            alloc2(k, 0, k + 1, 0);
        end
        pin("burst", 6, 7, 1, 10);

        for (int k = 0; k < 5; k++) alloc2(k, 0, k, 0);
        pin("full", -1, -1, 0, 0);

        free_en_1 = 1; free_idx_1 = 4'd7; req_1 = 1; step();
        pin("rel7", 7, -1, 0, 1);
        req_1 = 1; step();
        pin("one_free_req", 7, -1, 0, 1);

        free_en_2 = 1; free_idx_2 = 4'd8; step();
        pin("rel8", 7, 8, 1, 2);
        stall_DP = 1; req_1 = 1; req_2 = 1; step();
        pin("stall", 7, 8, 1, 2);

        req_1 = 1; free_en_1 = 1; free_idx_1 = 4'd0; free_en_2 = 1; free_idx_2 = 4'd0; step();
        pin("dup_rel", 0, 8, 1, 2);
        req_1 = 1; free_en_1 = 1; free_idx_1 = 4'd8; free_en_2 = 1; free_idx_2 = 4'd9; step();
        pin("stale_rel", 8, 9, 1, 2);
        req_2 = 1; step();
        pin("slot2_only", 8, -1, 0, 1);

`ifdef IQ_ALLOC_SELECTIVE_FLUSH_EN
        do_reset();
        for (int k = 0; k < 4; k++) alloc2(10 + 2 * k, 0, 11 + 2 * k, 0);
        pin("sel_fill", 8, 9, 1, 8);
        prmiss = 1; prmiss_rob_num = 6'd13; req_1 = 1; req_2 = 1; step();
        pin("sel_flush", 4, 5, 1, 12);

        do_reset();
        alloc2(62, 0, 63, 0);
        alloc2(0, 1, 1, 1);
        pin("wrap_fill", 4, 5, 1, 12);
        prmiss = 1; prmiss_rob_num = 6'd63; prmiss_rob_sorting_bit = 0; step();
        pin("wrap_flush", 2, 3, 1, 14);
`else
        do_reset();
        alloc2(0, 0, 1, 0);
        alloc2(2, 0, 3, 0);
        req_1 = 1; step();
        pin("five_busy", 5, 6, 1, 11);
        prmiss = 1; req_1 = 1; req_2 = 1; free_en_1 = 1; free_idx_1 = 4'd2; step();
        pin("full_flush", 0, 1, 1, 16);
`endif

        alloc2(0, 0, 1, 0);
        pin("pre_reset", 2, 3, 1, 14);
        reset = 1; req_1 = 1; req_2 = 1; step();
        reset = 0;
        pin("mid_reset", 0, 1, 1, 16);
        step();
        pin("after_reset", 0, 1, 1, 16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iq_alloc.md
# iq_alloc

Issue-queue entry allocator sitting directly upstream of the issue queue at dispatch. It tracks which issue-queue entries are occupied and supplies up to two free entry indices per cycle, as `iq_entry_num_1` and `iq_entry_num_2`. It reclaims entries when the select stage issues them and on branch-misprediction recovery. It also raises `allocatable` so dispatch can stall when fewer than two entries are free.

## Interface
- `ENT_NUM`, default 16: number of issue-queue entries.
- `ENT_SEL`, default 4: entry index width; equals clog2(`ENT_NUM`).
- `ROB_SEL`, default 6: ROB index width.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `req_1`, `req_2` in 1: dispatch slot 1/2 needs an entry (the inverse of the issue queue's `invalid1`/`invalid2`).
- `stall_DP` in 1: dispatch stalled; no allocation this cycle.
- `rob_num_1`, `rob_num_2` in `ROB_SEL`: ROB index of the slot 1/2 instruction.
- `rob_sorting_bit_1`, `rob_sorting_bit_2` in 1: ROB wrap bit of the slot 1/2 instruction.
- `free_en_1`, `free_en_2` in 1: select stage issued an entry; release it.
- `free_idx_1`, `free_idx_2` in `ENT_SEL`: index of the entry being released.
- `prmiss` in 1: branch misprediction recovery request.
- `prmiss_rob_num` in `ROB_SEL`: ROB index of the mispredicted branch.
- `prmiss_rob_sorting_bit` in 1: ROB wrap bit of the mispredicted branch.
- `iq_entry_num_1` out `ENT_SEL`: lowest-index free entry.
- `iq_entry_num_2` out `ENT_SEL`: second-lowest-index free entry.
- `allocatable` out 1: `free_cnt` ≥ 2.
- `free_cnt` out `ENT_SEL`+1: number of free entries.

## Operation
- State:
  - `busy[ENT_NUM]`: occupancy bit per entry.
  - Per-entry `rob[ROB_SEL]` and `sb`: owner ROB tag and wrap bit.
  - `free_cnt` register.
- Entry selection, combinational from `busy`:
  - `iq_entry_num_1` is the lowest index with `busy == 0`.
  - `iq_entry_num_2` is the next free index above it.
  - If no such index exists, the output is 0 and is meaningless; `allocatable` is 0 in that case.
- Allocation condition: `alloc_k = req_k & ~stall_DP & ~prmiss & allocatable`.
  - Dispatch must not assert a request without `allocatable`.
  - If it does, that request is ignored.
- Slot mapping:
  - Slot 1 always takes `iq_entry_num_1`.
  - Slot 2 takes `iq_entry_num_2`, even when `req_1 = 0`; this keeps the slot-to-index mapping fixed.
- On allocation: set `busy`, and capture `rob_num_k` and `rob_sorting_bit_k` into the entry.
- Release: `free_en_k` clears `busy[free_idx_k]`.
  - Releasing an entry that is already free has no effect.
  - Two releases of the same index in one cycle count once.
- Entries released in cycle N are not offered for allocation until cycle N+1; selection uses registered `busy` only.
- Same-cycle allocate and release to different entries both take effect.
- `free_cnt` update, next value: current − allocations + actual releases, where actual releases counts only entries that were busy and not double-counted. The count never wraps.
- Misprediction: see Configuration. `prmiss` suppresses allocation in that cycle; releases in the same cycle are still applied.
- Reset: `busy` is all 0 and `free_cnt` = `ENT_NUM`. Reset overrides every other input. Stored ROB tags are don't-care.

## Timing
- All outputs are combinational from registered state; zero-cycle lookup.
- State changes at the posedge of the cycle in which the allocation, release, or recovery is asserted.
- Output values after reset (`ENT_NUM` = 16): `iq_entry_num_1` = 0, `iq_entry_num_2` = 1, `allocatable` = 1, `free_cnt` = 16.
- Full queue: `free_cnt` = 0 and `allocatable` = 0.
- With exactly one entry free, `allocatable` = 0, so dispatch stalls even for a single request.
- `reset` asserted mid-operation empties the queue at the next edge; pending requests are dropped.

## Configuration
- Macro: `IQ_ALLOC_SELECTIVE_FLUSH_EN`.
- Defined (selective flush): on `prmiss`, clear each busy entry that is strictly younger than the branch.
  - If `sb == prmiss_rob_sorting_bit`, the entry is younger when `rob > prmiss_rob_num`.
  - Otherwise, the entry is younger when `rob < prmiss_rob_num`.
  - An equal tag is the branch itself and is kept.
  - `free_cnt` increases by the number of cleared entries plus the actual releases.
- Undefined (full flush): `prmiss` clears all `busy` bits and sets `free_cnt` = `ENT_NUM`. The per-entry ROB tag storage is not built.

## Test plan
- Reset, then `req_1` = `req_2` = 1 for 3 cycles → indices (0,1), (2,3), (4,5); `free_cnt` = 10.
- Fill all 16 entries → `allocatable` = 0.
  - Then `free_en_1` = 1 with `free_idx_1` = 7 → next cycle `iq_entry_num_1` = 7, `free_cnt` = 1, `allocatable` = 0.
- Same cycle: allocate with `req_1` only while releasing entries 0 and 0 (duplicate index) plus an already-free index → `free_cnt` decrements by 1 for the allocation and increments by 1 for the release.
- Selective flush (macro on): 8 entries with ROB 10..17 and `sb` = 0; `prmiss` with ROB 13, sb 0 → entries for ROB 14..17 freed; `free_cnt` = 12; the `req` asserted in that cycle is not granted.
- Wrap case (macro on): entries with ROB 62 and 63 (`sb` = 0) plus ROB 0 and 1 (`sb` = 1); `prmiss` with ROB 63, `sb` 0 → only the ROB 0 and 1 entries freed.
- Macro off: `prmiss` with 5 busy entries → `free_cnt` = 16; assert `reset` mid-allocation burst → the next cycle shows the post-reset output values.
